// File: rtl/pattgen_pkg.sv
// Shared definitions for the multi-channel pattern generator: mode encodings,
// advance-counter width and per-width maximal-length LFSR tap masks.
package pattgen_pkg;

    typedef enum logic [1:0] {
        MODE_CONST = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_LFSR  = 2'b10,
        MODE_WALK  = 2'b11
    } mode_e;

    localparam int unsigned ADV_CNT_W = 16;

    // Tap mask for a Fibonacci LFSR shifting left with feedback into bit0.
    function automatic logic [7:0] lfsr_taps(input int unsigned width);
        logic [7:0] taps;
        case (width)
            4:       taps = 8'h09;
            5:       taps = 8'h12;
            6:       taps = 8'h21;
            7:       taps = 8'h41;
            8:       taps = 8'h8E;
            default: taps = 8'h09;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/pattgen_prescaler.sv
// Free-running prescaler: counts 0..DIV-1 while run is high and emits a
// one-cycle tick on the terminal count; dropping run clears it.
module pattgen_prescaler #(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);
    assign tick_o  = run_i && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (at_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pattgen_multi.sv
// Multi-channel test-pattern generator: CONST, COUNT, LFSR and WALK modes,
// advanced by a step pulse or a prescaled free-run tick.
module pattgen_multi
    import pattgen_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 4,
    parameter int unsigned DIV   = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic                   step,
    input  logic                   run,
    output logic [NCH*WIDTH-1:0]   data,
    output logic                   valid,
    output logic [ADV_CNT_W-1:0]   adv_count
);

    localparam int unsigned   PW   = $clog2(WIDTH);
    localparam logic [7:0]    TAP8 = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAP = TAP8[WIDTH-1:0];

    mode_e                 mode_q;
    logic [WIDTH-1:0]      base_q;
    logic [PW-1:0]         ptr_q;
    logic                  valid_q;
    logic [ADV_CNT_W-1:0]  cnt_q;

    logic tick;
    logic reload;
    logic do_adv;

    pattgen_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_i  (run),
        .tick_o (tick)
    );

    // A mode change wins over a simultaneous advance, which is dropped.
    assign reload = (mode_e'(mode) != mode_q);
    assign do_adv = !reload && (step || tick) && (mode_q != MODE_CONST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_CONST;
            base_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else if (reload) begin
            mode_q  <= mode_e'(mode);
            base_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b1;
            cnt_q   <= '0;
        end else if (do_adv) begin
            valid_q <= 1'b1;
            cnt_q   <= cnt_q + ADV_CNT_W'(1);
            if (mode_q == MODE_COUNT) begin
                base_q <= base_q + WIDTH'(1);
            end
            if (mode_q == MODE_WALK) begin
                ptr_q <= (ptr_q == PW'(WIDTH - 1)) ? '0 : ptr_q + PW'(1);
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign valid     = valid_q;
    assign adv_count = cnt_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] lfsr_q;
        logic [WIDTH-1:0] ch;

        // Seed i+1 is nonzero for every legal WIDTH/NCH pair, so the LFSR
        // can never reach its lock-up state.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lfsr_q <= WIDTH'(i + 1);
            end else if (reload) begin
                lfsr_q <= WIDTH'(i + 1);
            end else if (do_adv && (mode_q == MODE_LFSR)) begin
                lfsr_q <= {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAP)};
            end
        end

        always_comb begin
            ch = '0;
            case (mode_q)
                MODE_CONST: ch = WIDTH'(i + 1);
                MODE_COUNT: ch = base_q + WIDTH'(i);
                MODE_LFSR:  ch = lfsr_q;
                MODE_WALK:  ch = WIDTH'(1) << ((32'(ptr_q) + i) % WIDTH);
                default:    ch = '0;
            endcase
        end

        assign data[i*WIDTH +: WIDTH] = ch;
    end

endmodule

// File: tb/tb_pattgen_multi.sv
// Scoreboard bench for pattgen_multi (WIDTH=4, NCH=4, DIV=4): a behavioural
// model predicts data/valid/adv_count for every clock and queues the result.
module tb_pattgen_multi;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        step;
    logic        run;
    logic [15:0] data;
    logic        valid;
    logic [15:0] adv_count;

    pattgen_multi #(
        .WIDTH (4),
        .NCH   (4),
        .DIV   (DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .step      (step),
        .run       (run),
        .data      (data),
        .valid     (valid),
        .adv_count (adv_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] data;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    // Model state: current mode, advances since reload, valid, count, prescaler.
    logic [1:0] m;
    int         k;
    logic       mv;
    int         cnt;
    int         psc;

    logic [3:0] seq [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                             4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int seq_pos(input int v);
        for (int j = 0; j < 15; j++) begin
            if (int'(seq[j]) == v) return j;
        end
        return 0;
    endfunction

    function automatic logic [15:0] model_data();
        logic [15:0] r;
        logic [3:0]  c;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            case (m)
                2'b00:   c = 4'(i + 1);
                2'b01:   c = 4'((k + i) % 16);
                2'b10:   c = seq[(seq_pos(i + 1) + k) % 15];
                default: c = 4'(1 << ((k + i) % 4));
            endcase
            r[i*4 +: 4] = c;
        end
        return r;
    endfunction

    task automatic model_reset();
        m = 2'b00; k = 0; mv = 1'b0; cnt = 0; psc = 0;
    endtask

    // Predict the effect of the currently driven inputs, clock once, compare.
    task automatic drive_cycle(input string tag);
        exp_t e;
        bit   tick;
        tick = run && (psc == DIV - 1);
        psc  = run ? ((psc == DIV - 1) ? 0 : psc + 1) : 0;
        if (mode != m) begin
            m = mode; k = 0; mv = 1'b1; cnt = 0;
        end else if ((step || tick) && m != 2'b00) begin
            k++; mv = 1'b1; cnt = (cnt + 1) % 65536;
        end else begin
            mv = 1'b0;
        end
        e.tag = tag; e.data = model_data(); e.valid = mv; e.cnt = 16'(cnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, "_data"},  32'(data),      32'(e.data));
        check({e.tag, "_valid"}, 32'(valid),     32'(e.valid));
        check({e.tag, "_cnt"},   32'(adv_count), 32'(e.cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c0;
        bit did;

        rst_n = 1'b0; mode = 2'b00; step = 1'b0; run = 1'b0;
        model_reset();
        #3;
        check("rst_data",  32'(data),      32'h4321);
        check("rst_valid", 32'(valid),     32'h0);
        check("rst_cnt",   32'(adv_count), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_cycle("idle");

        // CONST ignores advances
        repeat (3) begin
            step = 1'b1; drive_cycle("const_step");
            step = 1'b0; drive_cycle("const_idle");
        end
        check("const_final", 32'(data),      32'h4321);
        check("const_cnt",   32'(adv_count), 32'h0);

        // COUNT
        mode = 2'b01;
        drive_cycle("count_reload");
        check("count_seed", 32'(data), 32'h3210);
        for (int j = 0; j < 15; j++) begin
            step = 1'b1; drive_cycle("count_step");
            if (j == 0) check("count_first", 32'(data), 32'h4321);
            step = 1'b0; drive_cycle("count_idle");
        end
        check("count_15_data", 32'(data),      32'h210F);
        check("count_15_cnt",  32'(adv_count), 32'd15);

        // LFSR
        mode = 2'b10;
        drive_cycle("lfsr_reload");
        for (int j = 0; j < 15; j++) begin
            step = 1'b1; drive_cycle("lfsr_step");
            check("lfsr_nonzero", 32'(data[3:0] != 4'h0), 32'h1);
            step = 1'b0; drive_cycle("lfsr_idle");
        end
        check("lfsr_wrap", 32'(data[3:0]), 32'h1);

        // WALK free-running, with one step landing on a tick cycle
        mode = 2'b11; run = 1'b1;
        drive_cycle("walk_reload");
        check("walk_seed", 32'(data), 32'h8421);
        did = 1'b0;
        for (int j = 0; j < 24; j++) begin
            if (!did && j > 8 && psc == DIV - 1) begin
                step = 1'b1; did = 1'b1; c0 = cnt;
                drive_cycle("walk_tick_step");
                check("tick_step_once", 32'(adv_count), 32'(c0 + 1));
                step = 1'b0;
            end else begin
                drive_cycle("walk_run");
            end
        end
        check("tick_step_seen", 32'(did), 32'h1);
        run = 1'b0;
        repeat (3) drive_cycle("walk_stop");

        // Mode change coinciding with step: reload only
        mode = 2'b01;
        drive_cycle("coll_count");
        step = 1'b1; drive_cycle("coll_step");
        step = 1'b0; drive_cycle("coll_idle");
        mode = 2'b11; step = 1'b1;
        drive_cycle("coll_change");
        step = 1'b0;
        check("coll_data",  32'(data),      32'h8421);
        check("coll_cnt",   32'(adv_count), 32'h0);
        check("coll_valid", 32'(valid),     32'h1);
        drive_cycle("coll_after");
        check("coll_single_pulse", 32'(valid), 32'h0);

        // Asynchronous reset in the middle of COUNT
        mode = 2'b01;
        drive_cycle("mid_reload");
        repeat (3) begin
            step = 1'b1; drive_cycle("mid_step");
            step = 1'b0; drive_cycle("mid_idle");
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_data",  32'(data),      32'h4321);
        check("arst_valid", 32'(valid),     32'h0);
        check("arst_cnt",   32'(adv_count), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_cycle("post_rst_reload");
        check("post_rst_seed", 32'(data), 32'h3210);
        drive_cycle("post_rst_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
